// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 32-bit data memory port between requester A
// (CPU execute) and requester B (loader/debug), with a bounded burst lock for B.
module dmem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          a_req,
  input  logic [3:0]    a_wren,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic [3:0]    b_wren,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_lock,
  output logic          a_ack,
  output logic          b_ack,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wren,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic [15:0]   conflict_cnt
);

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          last_gnt_b;
  logic [BW-1:0] burst_cnt;

  assign owner = state;

  always_comb begin
    next_state = IDLE;
    if (a_req && !b_req) begin
      next_state = OWN_A;
    end else if (!a_req && b_req) begin
      next_state = OWN_B;
    end else if (a_req && b_req) begin
      if (state == OWN_B && b_lock && burst_cnt < BURST_LIMIT) begin
        next_state = OWN_B;
      end else if (last_gnt_b) begin
        next_state = OWN_A;
      end else begin
        next_state = OWN_B;
      end
    end
  end

  // Port mux decodes straight from state so a reset kills the write strobe at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = '1;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    unique case (state)
      OWN_A: begin
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        mem_wren  = a_wren;
        a_ack     = 1'b1;
      end
      OWN_B: begin
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
        mem_wren  = b_wren;
        b_ack     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state        <= IDLE;
      last_gnt_b   <= 1'b1;
      burst_cnt    <= '0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= next_state;

      if (next_state == OWN_A) begin
        last_gnt_b <= 1'b0;
      end else if (next_state == OWN_B) begin
        last_gnt_b <= 1'b1;
      end

      if (next_state == OWN_B) begin
        if (state != OWN_B) begin
          burst_cnt <= BW'(1);
        end else if (burst_cnt != BURST_LIMIT) begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end else begin
        burst_cnt <= '0;
      end

      // Captured alongside the bank write, so this is the pre-write word.
      if (state == OWN_A) begin
        a_rdata <= mem_rdata;
      end
      if (state == OWN_B) begin
        b_rdata <= mem_rdata;
      end

      if (a_req && b_req && conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 32-bit data memory (four 8-bit byte banks, 256 words, active-low byte write enables) between requester A (CPU execute stage) and requester B (host loader / debug port). It grants one word access per cycle using round-robin priority, with an optional bounded burst lock for B. It returns a registered read word to the owner and keeps a saturating contention counter for performance monitoring.

## Interface
- AW, 8, word address width
- DW, 32, data width (4 byte lanes)
- MAX_BURST, 4, max consecutive locked B grants while A is waiting (≥1)
- clk  in  1  system clock; all state updates on posedge
- rstd  in  1  reset, asynchronous, active-high
- a_req, b_req  in  1  access request; once high, held high with stable fields until the matching ack
- a_wren, b_wren  in  4  byte write enables, active-low per lane; 4'b1111 = read
- a_addr, b_addr  in  AW  word address
- a_wdata, b_wdata  in  DW  write data
- b_lock  in  1  B asks to keep ownership across consecutive requests
- a_ack, b_ack  out  1  high during the cycle the memory port serves that requester
- a_rdata, b_rdata  out  DW  registered read word, valid from the cycle after ack
- mem_addr  out  AW  to all four banks
- mem_wdata  out  DW  lane i = bits [8i+7:8i]
- mem_wren  out  4  active-low lane enables to banks
- mem_rdata  in  DW  combinational bank read of mem_addr
- owner  out  2  00 idle, 01 A, 10 B
- conflict_cnt  out  16  cycles with a_req and b_req both high, saturating at 16'hffff

## Operation
- States: IDLE, OWN_A, OWN_B (registered). owner reflects state directly.
- Memory port is a combinational mux from state. In OWN_x: mem_addr/mem_wdata/mem_wren = x fields; x_ack = 1. In IDLE: mem_addr = 0, mem_wdata = 0, mem_wren = 4'b1111, both acks 0.
- At each posedge in OWN_x: the banks perform the write; x_rdata <= mem_rdata. This is the pre-write word, with no write-through. The other requester's rdata holds its value.
- Next-state selection at each posedge, from sampled requests:
  - neither req: IDLE.
  - only A: OWN_A. Only B: OWN_B.
  - both, current OWN_B, b_lock = 1, burst_cnt < MAX_BURST: OWN_B.
  - both, otherwise: grant the requester not granted most recently (last_gnt).
- last_gnt updates to A or B on every entry into or stay in OWN_A or OWN_B. It is unchanged in IDLE.
- burst_cnt (width ≥ clog2(MAX_BURST)+1): set to 1 on entry to OWN_B from another state. Increments on each stay in OWN_B and saturates at MAX_BURST. Cleared to 0 when leaving OWN_B.
- If a_req is low, B keeps ownership indefinitely regardless of burst_cnt.
- conflict_cnt increments at each posedge where a_req & b_req, and saturates.
- A requester that wants back-to-back accesses keeps req high and changes its fields on the edge that ends its ack cycle.
- Protocol violation: dropping req before ack. The arbiter still serves the already-granted cycle using the current field values. The bench flags it.

## Timing
- Reset (async, immediate): state IDLE, last_gnt = B (so A wins the first tie), burst_cnt 0, a_rdata = b_rdata = 0, conflict_cnt 0. All combinational outputs take their IDLE values in the same cycle.
- Reset asserted mid-access: ack drops and mem_wren = 4'b1111 immediately, so no write occurs at the next edge.
- Latency: req first high in cycle t → ack in cycle t+1 (if it wins) → rdata valid in t+2.
- Sustained single requester: ack every cycle, one word per cycle.
- Alternating contention: A and B each get one ack every 2 cycles.
- With b_lock high and A waiting, B gets at most MAX_BURST consecutive acks, then A gets the next cycle.
- Write and rdata capture to the same address in one cycle: rdata = old word. A read in the following cycle returns the new word.

## Test plan
- Reset then idle: after rstd release with no reqs → owner 00, mem_wren 4'b1111, rdata 0, conflict_cnt 0 for 10 cycles.
- A writes 32'hdeadbeef to addr 5 with wren 4'b1100, then reads addr 5 → a_ack in cycles t+1 and t+2. Read returns 32'h????beef: upper lanes keep their prior value, lower 16 bits = beef.
- A and B request continuously from the same cycle, b_lock = 0 → acks A, B, A, B…; conflict_cnt increments once per cycle.
- b_lock = 1 with both requesting continuously, MAX_BURST = 4 → once B owns, exactly 4 B acks, then 1 A ack, then B again.
- Read-during-write: A writes 32'h12345678 to addr 9 (old value 0) with read capture in the same cycle → a_rdata = 0. Next A read of addr 9 → 32'h12345678.
- Assert rstd during OWN_B write cycle → b_ack and owner drop in the same cycle, mem_wren = 4'b1111, and the target word is unchanged.
